// File: rtl/mod_exp_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine among NREQ requesters.
// States: IDLE arbitrate | LOAD pulse engine load | RUN wait for finish | RESP hold response.
module mod_exp_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*2*WIDTH-1:0]   req_base,
    input  logic [NREQ*2*WIDTH-1:0]   req_modulo,
    input  logic [NREQ*2*WIDTH-1:0]   req_exponent,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [IDW-1:0]            resp_id,
    output logic [2*WIDTH-1:0]        resp_result,
    output logic                      resp_error,
    output logic                      busy,
    output logic [2*WIDTH-1:0]        eng_base,
    output logic [2*WIDTH-1:0]        eng_modulo,
    output logic [2*WIDTH-1:0]        eng_exponent,
    output logic                      eng_load,
    input  logic                      eng_finish,
    input  logic [2*WIDTH-1:0]        eng_result
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             grant_found;
    logic [W2-1:0]    base_arr [NREQ];
    logic [W2-1:0]    mod_arr  [NREQ];
    logic [W2-1:0]    exp_arr  [NREQ];
    logic [W2-1:0]    sel_base, sel_modulo, sel_exponent;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign base_arr[i] = req_base[i*W2 +: W2];
        assign mod_arr[i]  = req_modulo[i*W2 +: W2];
        assign exp_arr[i]  = req_exponent[i*W2 +: W2];
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_base     = base_arr[grant_idx];
    assign sel_modulo   = mod_arr[grant_idx];
    assign sel_exponent = exp_arr[grant_idx];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt = (sel_modulo <= W2'(1)) ? RESP : LOAD;
                end
            end
            LOAD:    state_nxt = RUN;
            RUN:     if (eng_finish) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (reset) req_ready = '0;
    end

    assign eng_load   = (state == LOAD) && !reset;
    assign resp_valid = (state == RESP) && !reset;
    assign busy       = (state != IDLE);

    // Degenerate moduli are answered at grant time; real jobs overwrite on finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= IDW'(NREQ - 1);
            resp_id      <= '0;
            resp_result  <= '0;
            resp_error   <= 1'b0;
            eng_base     <= '0;
            eng_modulo   <= '0;
            eng_exponent <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                eng_base     <= sel_base;
                eng_modulo   <= sel_modulo;
                eng_exponent <= sel_exponent;
                resp_id      <= grant_idx;
                rr_ptr       <= grant_idx;
                resp_result  <= '0;
                resp_error   <= (sel_modulo == '0);
            end
            if (state == RUN && eng_finish) begin
                resp_result <= eng_result;
                resp_error  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Scoreboard bench for mod_exp_arbiter with a behavioural engine whose finish lags by exponent bit-length.
module tb_mod_exp_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int W2    = 2 * WIDTH;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*W2-1:0]      req_base, req_modulo, req_exponent;
    logic                    resp_valid;
    logic                    resp_ready = 1'b1;
    logic [IDW-1:0]          resp_id;
    logic [W2-1:0]           resp_result;
    logic                    resp_error;
    logic                    busy;
    logic [W2-1:0]           eng_base, eng_modulo, eng_exponent;
    logic                    eng_load;
    logic                    eng_finish;
    logic [W2-1:0]           eng_result;

    logic [W2-1:0] base_s [NREQ];
    logic [W2-1:0] mod_s  [NREQ];
    logic [W2-1:0] exp_s  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_base[i*W2 +: W2]     = base_s[i];
        assign req_modulo[i*W2 +: W2]   = mod_s[i];
        assign req_exponent[i*W2 +: W2] = exp_s[i];
    end

    always #5 clk = ~clk;

    mod_exp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_modulo(req_modulo), .req_exponent(req_exponent),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_error(resp_error), .busy(busy),
        .eng_base(eng_base), .eng_modulo(eng_modulo), .eng_exponent(eng_exponent),
        .eng_load(eng_load), .eng_finish(eng_finish), .eng_result(eng_result)
    );

    // Engine stand-in: not reset by the arbiter; finish stays high until the next load.
    function automatic int bitlen(input logic [W2-1:0] v);
        int n = 0;
        for (int i = 0; i < W2; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [W2-1:0] modexp(input logic [W2-1:0] b, e, m);
        logic [2*W2-1:0] r, x;
        if (m == '0) return '0;
        r = (2*W2)'(1) % (2*W2)'(m);
        x = (2*W2)'(b % m);
        for (int i = 0; i < W2; i++) begin
            if (e[i]) r = (r * x) % (2*W2)'(m);
            x = (x * x) % (2*W2)'(m);
        end
        return r[W2-1:0];
    endfunction

    logic          eng_busy = 1'b0;
    int            eng_cnt  = 0;
    logic [W2-1:0] eng_res_q = '0;

    always @(posedge clk) begin
        if (eng_load) begin
            eng_busy  <= 1'b1;
            eng_cnt   <= bitlen(eng_exponent) + 1;
            eng_res_q <= modexp(eng_base, eng_exponent, eng_modulo);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end
    assign eng_finish = eng_busy && (eng_cnt == 0);
    assign eng_result = eng_finish ? eng_res_q : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [W2-1:0]  res;
        logic           err;
        int             at;
    } exp_t;

    exp_t sb[$];

    // Monitor: pops an expectation when a response first appears, then checks it is held.
    int             loads = 0;
    logic           in_resp = 1'b0;
    exp_t           mon_e;
    logic [IDW-1:0] cap_id;
    logic [W2-1:0]  cap_res;
    logic           cap_err;

    always @(negedge clk) begin
        if (reset) begin
            in_resp = 1'b0;
        end else begin
            if (eng_load) loads++;
            if (resp_valid) begin
                chk("resp_no_req_ready", 64'(req_ready), 64'd0);
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp id=%0d result=%0d required=none", resp_id, resp_result);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("resp_id", 64'(resp_id), 64'(mon_e.id));
                        chk("resp_result", resp_result, mon_e.res);
                        chk("resp_error", 64'(resp_error), 64'(mon_e.err));
                        chk("resp_latency_cycle", 64'(cyc), 64'(mon_e.at));
                    end
                    cap_id  = resp_id;
                    cap_res = resp_result;
                    cap_err = resp_error;
                    in_resp = 1'b1;
                end else begin
                    chk("hold_id", 64'(resp_id), 64'(cap_id));
                    chk("hold_result", resp_result, cap_res);
                    chk("hold_error", 64'(resp_error), 64'(cap_err));
                end
                if (resp_ready) in_resp = 1'b0;
            end
        end
    end

    task automatic issue(input logic [IDW-1:0] id, input logic [W2-1:0] b, m, e, r,
                         input logic err, input int lat, input bit push, output int acc);
        bit got = 0;
        @(posedge clk); #1;
        base_s[id] = b; mod_s[id] = m; exp_s[id] = e;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        acc = cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout id=%0d actual=no_ready required=ready", id);
        end else begin
            chk("accept_onehot", 64'(req_ready), 64'(1) << id);
            if (push) sb.push_back('{id: id, res: r, err: err, at: acc + lat});
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    localparam logic [W2-1:0] FR_RES [NREQ] = '{64'd2, 64'd4, 64'd8, 64'd5};
    localparam int            FR_LAT [NREQ] = '{5, 6, 6, 7};
    localparam int            ORDER  [8]    = '{0, 1, 2, 3, 0, 1, 3, 1};

    initial begin
        int a, l0;
        bit got;
        for (int i = 0; i < NREQ; i++) begin
            base_s[i] = '0; mod_s[i] = '0; exp_s[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_eng_load", 64'(eng_load), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        chk("rst_eng_modulo", eng_modulo, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single job on requester 2: 4^13 mod 497
        issue(2'd2, 64'd4, 64'd497, 64'd13, 64'd445, 1'b0, 8, 1, a);
        @(negedge clk);
        chk("load_pulse_a1", 64'(eng_load), 64'd1);
        chk("eng_base", eng_base, 64'd4);
        chk("eng_modulo", eng_modulo, 64'd497);
        chk("eng_exponent", eng_exponent, 64'd13);
        @(negedge clk);
        chk("load_pulse_a2", 64'(eng_load), 64'd0);
        drain();

        issue(2'd0, 64'd3, 64'd7, 64'd0, 64'd1, 1'b0, 4, 1, a);
        drain();

        // Degenerate moduli never reach the engine
        l0 = loads;
        issue(2'd1, 64'd9, 64'd0, 64'd5, 64'd0, 1'b1, 1, 1, a);
        issue(2'd3, 64'd9, 64'd1, 64'd5, 64'd0, 1'b0, 1, 1, a);
        drain();
        chk("degenerate_no_load", 64'(loads), 64'(l0));

        // Response backpressure with another requester waiting
        resp_ready = 1'b0;
        issue(2'd0, 64'd3, 64'd7, 64'd0, 64'd1, 1'b0, 4, 1, a);
        base_s[1] = 64'd5; mod_s[1] = 64'd23; exp_s[1] = 64'd3;
        req_valid[1] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (resp_valid) got = 1;
        end
        chk("hold_resp_seen", 64'(got), 64'd1);
        repeat (6) begin
            @(negedge clk);
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        issue(2'd1, 64'd5, 64'd23, 64'd3, 64'd10, 1'b0, 6, 1, a);
        drain();

        // Reset in RUN; engine keeps going and leaves a stale finish behind
        l0 = loads;
        issue(2'd2, 64'd4, 64'd497, 64'd13, 64'd0, 1'b0, 0, 0, a);
        repeat (2) @(negedge clk);
        chk("run_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_no_load", 64'(eng_load), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        repeat (5) @(negedge clk);
        chk("reset_single_load", 64'(loads), 64'(l0 + 1));
        chk("stale_finish_present", 64'(eng_finish), 64'd1);
        issue(2'd1, 64'd5, 64'd23, 64'd3, 64'd10, 1'b0, 6, 1, a);
        drain();

        // Fairness: all four valid, then only 1 and 3
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            base_s[i] = 64'd2; mod_s[i] = 64'd11; exp_s[i] = 64'(i + 1);
        end
        @(posedge clk); #1 req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            got = 0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1;
            end
            chk("grant_order", 64'(req_ready), 64'(1) << ORDER[j]);
            if (got) sb.push_back('{id: IDW'(ORDER[j]), res: FR_RES[ORDER[j]], err: 1'b0,
                                    at: cyc + FR_LAT[ORDER[j]]});
            if (j == 4) begin
                @(posedge clk); #1 req_valid = 4'b1010;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
